// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop resynchronizer for the asynchronous serial line. Both stages reset
// to 1 so that a reset never manufactures a falling edge on an idle line.
//
// Ports
//   clock_i  : receiver clock, rising edge
//   reset_i  : synchronous, active-high reset (forces both stages to 1)
//   async_i  : asynchronous input (serial line)
//   sync_o   : async_i delayed by two clock_i cycles, safe to use in logic
// -----------------------------------------------------------------------------
module uart_sync (
    input  logic clock_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_r;

    // Two-stage resynchronizer, idle-high reset value.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            meta_r <= 1'b1;
            sync_o <= 1'b1;
        end else begin
            meta_r <= async_i;
            sync_o <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 8 data bits LSB first, optional parity bit, one or two stop
// bits, run-time programmable bit period of D clock_i cycles (D < 2 -> 2).
//
// Ports
//   clock_i          : sole clock, rising edge
//   reset_i          : synchronous, active-high reset
//   serial_i         : asynchronous serial line, idle high
//   two_stop_bits_i  : 1 = frame has two stop bits
//   parity_bit_i     : 1 = frame carries a parity bit after data bit 7
//   parity_even_i    : 1 = even parity, 0 = odd
//   clock_divider_i  : clock_i cycles per bit (D)
//   data_o           : last received byte (held until the next valid_o)
//   valid_o          : one-cycle pulse, data_o and error flags are fresh
//   parity_error_o   : parity mismatch in the last frame
//   framing_error_o  : a stop bit of the last frame was sampled low
//   busy_o           : high from start-bit detection until frame end/reject
//
// Timing: start edge detected 2 cycles after the line falls (synchronizer),
// start bit checked floor(D/2) cycles later, every further bit exactly D
// cycles after the previous sample, valid_o one cycle after the last stop
// sample. Configuration is captured at start detection and held per frame.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLOCK_DIVIDER_WIDTH = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           serial_i,
    input  logic                           two_stop_bits_i,
    input  logic                           parity_bit_i,
    input  logic                           parity_even_i,
    input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    output logic                           parity_error_o,
    output logic                           framing_error_o,
    output logic                           busy_o
);

    localparam int DW = CLOCK_DIVIDER_WIDTH;

    localparam logic [DW-1:0] DIV_ZERO = DW'(0);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_TWO  = DW'(2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP1     = 3'd4,
        STOP2     = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    // True when the received parity bit does not match the selected parity
    // over the 8 data bits.
    function automatic logic parity_mismatch(
        input logic [7:0] data,
        input logic       parity,
        input logic       even
    );
        logic expected_xor;
        if (even) begin
            expected_xor = 1'b0;
        end else begin
            expected_xor = 1'b1;
        end
        return (((^data) ^ parity) != expected_xor);
    endfunction

    // Synchronized line and its previous value for edge detection.
    logic line_s;
    logic line_prev_r;

    // Frame state.
    state_t         state_r;
    logic [DW-1:0]  cnt_r;          // cycles remaining until next sample
    logic [DW-1:0]  div_r;          // latched, clamped bit period
    logic [2:0]     bit_cnt_r;      // data bit index
    logic [7:0]     shift_r;        // data shift register, LSB arrives first
    logic           two_stop_r;
    logic           parity_en_r;
    logic           parity_even_r;
    logic           parity_err_r;
    logic           framing_err_r;
    logic           done_r;         // frame complete, publish next cycle

    // Derived combinational values.
    logic [DW-1:0]  div_clamped_s;
    logic [DW-1:0]  half_load_s;
    logic [DW-1:0]  bit_reload_s;
    logic           sample_tick_s;

    uart_sync u_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .async_i (serial_i),
        .sync_o  (line_s)
    );

    // Divider clamping and counter reload values.
    always_comb begin
        div_clamped_s = clock_divider_i;
        half_load_s   = DIV_ZERO;
        bit_reload_s  = DIV_ZERO;
        sample_tick_s = 1'b0;
        if (clock_divider_i < DIV_TWO) begin
            div_clamped_s = DIV_TWO;
        end else begin
            div_clamped_s = clock_divider_i;
        end
        // Counter counts down to zero, so a wait of N cycles loads N-1.
        half_load_s   = {1'b0, div_clamped_s[DW-1:1]} - DIV_ONE;
        bit_reload_s  = div_r - DIV_ONE;
        if (cnt_r == DIV_ZERO) begin
            sample_tick_s = 1'b1;
        end else begin
            sample_tick_s = 1'b0;
        end
    end

    // Receiver FSM, sampling counters and registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            line_prev_r     <= 1'b1;
            state_r         <= IDLE;
            cnt_r           <= DIV_ZERO;
            div_r           <= DIV_TWO;
            bit_cnt_r       <= 3'd0;
            shift_r         <= 8'h00;
            two_stop_r      <= 1'b0;
            parity_en_r     <= 1'b0;
            parity_even_r   <= 1'b0;
            parity_err_r    <= 1'b0;
            framing_err_r   <= 1'b0;
            done_r          <= 1'b0;
            data_o          <= 8'h00;
            valid_o         <= 1'b0;
            parity_error_o  <= 1'b0;
            framing_error_o <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            line_prev_r <= line_s;
            done_r      <= 1'b0;
            valid_o     <= 1'b0;

            // Publish stage: one cycle after the final stop sample.
            if (done_r) begin
                valid_o         <= 1'b1;
                data_o          <= shift_r;
                parity_error_o  <= parity_err_r;
                framing_error_o <= framing_err_r;
            end

            case (state_r)
                IDLE: begin
                    if (line_prev_r && !line_s) begin
                        state_r       <= START;
                        busy_o        <= 1'b1;
                        div_r         <= div_clamped_s;
                        two_stop_r    <= two_stop_bits_i;
                        parity_en_r   <= parity_bit_i;
                        parity_even_r <= parity_even_i;
                        cnt_r         <= half_load_s;
                    end
                end

                START: begin
                    if (sample_tick_s) begin
                        if (line_s) begin
                            // Line back high mid start bit: glitch, drop it.
                            state_r <= IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            state_r       <= DATA;
                            cnt_r         <= bit_reload_s;
                            bit_cnt_r     <= 3'd0;
                            parity_err_r  <= 1'b0;
                            framing_err_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end

                DATA: begin
                    if (sample_tick_s) begin
                        shift_r <= {line_s, shift_r[7:1]};
                        cnt_r   <= bit_reload_s;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            if (parity_en_r) begin
                                state_r <= PARITY;
                            end else begin
                                state_r <= STOP1;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end

                PARITY: begin
                    if (sample_tick_s) begin
                        parity_err_r <= parity_mismatch(shift_r, line_s, parity_even_r);
                        cnt_r        <= bit_reload_s;
                        state_r      <= STOP1;
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end

                STOP1: begin
                    if (sample_tick_s) begin
                        framing_err_r <= !line_s;
                        if (two_stop_r) begin
                            cnt_r   <= bit_reload_s;
                            state_r <= STOP2;
                        end else begin
                            // Low line at the last stop sample means break:
                            // stay busy until the line is seen high again.
                            done_r <= 1'b1;
                            busy_o <= !line_s;
                            if (line_s) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= WAIT_HIGH;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end

                STOP2: begin
                    if (sample_tick_s) begin
                        framing_err_r <= framing_err_r | !line_s;
                        done_r        <= 1'b1;
                        busy_o        <= !line_s;
                        if (line_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= WAIT_HIGH;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_ONE;
                    end
                end

                WAIT_HIGH: begin
                    if (line_s) begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end

                default: begin
                    state_r <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frame drivers push the expected byte, flags,
// busy level and publish cycle into a queue; a monitor records every valid_o
// pulse; each scenario task pops both and compares inline.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CDW = 8;

    logic           clock_i = 1'b0;
    logic           reset_i;
    logic           serial_i;
    logic           two_stop_bits_i;
    logic           parity_bit_i;
    logic           parity_even_i;
    logic [CDW-1:0] clock_divider_i;
    logic [7:0]     data_o;
    logic           valid_o;
    logic           parity_error_o;
    logic           framing_error_o;
    logic           busy_o;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
        int         cyc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_rx #(.CLOCK_DIVIDER_WIDTH(CDW)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .serial_i        (serial_i),
        .two_stop_bits_i (two_stop_bits_i),
        .parity_bit_i    (parity_bit_i),
        .parity_even_i   (parity_even_i),
        .clock_divider_i (clock_divider_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .parity_error_o  (parity_error_o),
        .framing_error_o (framing_error_o),
        .busy_o          (busy_o)
    );

    always #5 clock_i = ~clock_i;

    always @(posedge clock_i) cyc <= cyc + 1;

    always @(negedge clock_i) begin
        if (valid_o === 1'b1)
            obs_q.push_back('{data_o, parity_error_o, framing_error_o, busy_o, cyc});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // Hold the line at v for n clock edges; returns 1ns after the last edge.
    task automatic drive_bit(input logic v, input int n);
        serial_i = v;
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic get_obs(input int budget, output rec_t o, output bit ok);
        ok = 1'b0;
        o  = '{8'h00, 1'b0, 1'b0, 1'b0, -1};
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() != 0) break;
            @(negedge clock_i);
        end
        if (obs_q.size() != 0) begin
            o  = obs_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Drive one frame and push its expected outcome.
    task automatic send_frame(input logic [7:0] d, input int div, input bit par_en,
                              input bit even, input bit pbit, input bit two_stop,
                              input bit stop2_low, input bit scramble);
        int   bt;
        int   n;
        rec_t e;
        bt = (div < 2) ? 2 : div;
        n  = 9 + (par_en ? 1 : 0) + (two_stop ? 1 : 0);
        clock_divider_i = div[CDW-1:0];
        parity_bit_i    = par_en;
        parity_even_i   = even;
        two_stop_bits_i = two_stop;
        e.data = d;
        e.perr = par_en && (((^d) ^ pbit) != (even ? 1'b0 : 1'b1));
        e.ferr = two_stop && stop2_low;
        e.busy = two_stop && stop2_low;
        e.cyc  = cyc + 1 + 2 + bt / 2 + n * bt + 1;
        exp_q.push_back(e);
        drive_bit(1'b0, bt);
        if (scramble) begin
            clock_divider_i = 8'd9;
            parity_bit_i    = ~par_en;
            parity_even_i   = ~even;
            two_stop_bits_i = ~two_stop;
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], bt);
        if (par_en) drive_bit(pbit, bt);
        drive_bit(1'b1, bt);
        if (two_stop) drive_bit(~stop2_low, bt);
        serial_i        = 1'b1;
        clock_divider_i = div[CDW-1:0];
        parity_bit_i    = par_en;
        parity_even_i   = even;
        two_stop_bits_i = two_stop;
    endtask

    task automatic test_reset();
        reset_i         = 1'b1;
        serial_i        = 1'b1;
        two_stop_bits_i = 1'b0;
        parity_bit_i    = 1'b0;
        parity_even_i   = 1'b0;
        clock_divider_i = 8'd4;
        repeat (3) @(posedge clock_i);
        #1;
        checks++;
        if ({data_o, valid_o, parity_error_o, framing_error_o, busy_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: got {data,valid,perr,ferr,busy}=%h expected 000",
                     {data_o, valid_o, parity_error_o, framing_error_o, busy_o});
        end
        reset_i = 1'b0;
        drive_bit(1'b1, 5);
    endtask

    task automatic test_basic_8n1();
        rec_t o;
        rec_t e;
        bit   ok;
        send_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        get_obs(200, o, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {e.data, e.perr, e.ferr, e.busy}) begin
            errors++;
            $display("FAIL basic_frame: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=%h perr=%b ferr=%b busy=%b",
                     ok, o.data, o.perr, o.ferr, o.busy, e.data, e.perr, e.ferr, e.busy);
        end
        checks++;
        if (!ok || o.cyc != e.cyc) begin
            errors++;
            $display("FAIL basic_latency: valid at cycle %0d, expected %0d", o.cyc, e.cyc);
        end
        drive_bit(1'b1, 60);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL basic_single_valid: %0d extra valid pulses, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        rec_t o;
        rec_t e;
        bit   ok;
        // Configuration is scrambled mid-frame; each frame must keep its own.
        send_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            get_obs(200, o, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {e.data, e.perr, e.ferr, e.busy}) begin
                errors++;
                $display("FAIL b2b_frame%0d: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=%h perr=%b ferr=%b busy=%b",
                         k, ok, o.data, o.perr, o.ferr, o.busy, e.data, e.perr, e.ferr, e.busy);
            end
            checks++;
            if (!ok || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL b2b_latency%0d: valid at cycle %0d, expected %0d", k, o.cyc, e.cyc);
            end
        end
        drive_bit(1'b1, 60);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra_valid: %0d extra valid pulses, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_parity();
        rec_t       o;
        rec_t       e;
        bit         ok;
        logic [7:0] pd [4]  = '{8'h07, 8'h07, 8'h07, 8'hC3};
        bit         pev [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit         pbv [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        bit         perr_req [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            send_frame(pd[k], 4, 1'b1, pev[k], pbv[k], 1'b0, 1'b0, 1'b0);
            get_obs(200, o, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {e.data, perr_req[k], 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL parity_case%0d: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=%h perr=%b ferr=0 busy=0",
                         k, ok, o.data, o.perr, o.ferr, o.busy, e.data, perr_req[k]);
            end
            checks++;
            if (!ok || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL parity_latency%0d: valid at cycle %0d, expected %0d", k, o.cyc, e.cyc);
            end
            drive_bit(1'b1, 10);
        end
    endtask

    task automatic test_two_stop();
        rec_t o;
        rec_t e;
        bit   ok;
        send_frame(8'h3C, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 10);
        for (int k = 0; k < 2; k++) begin
            get_obs(200, o, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {e.data, e.perr, e.ferr, e.busy}) begin
                errors++;
                $display("FAIL two_stop_frame%0d: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=%h perr=%b ferr=%b busy=%b",
                         k, ok, o.data, o.perr, o.ferr, o.busy, e.data, e.perr, e.ferr, e.busy);
            end
            checks++;
            if (!ok || o.cyc != e.cyc) begin
                errors++;
                $display("FAIL two_stop_latency%0d: valid at cycle %0d, expected %0d", k, o.cyc, e.cyc);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL two_stop_rearm: busy_o=%b, expected 0", busy_o);
        end
    endtask

    task automatic test_min_divider();
        rec_t o;
        rec_t e;
        bit   ok;
        send_frame(8'h96, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        get_obs(200, o, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {o.data, o.perr, o.ferr} !== {e.data, e.perr, e.ferr}) begin
            errors++;
            $display("FAIL min_div_frame: seen=%0b data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                     ok, o.data, o.perr, o.ferr, e.data, e.perr, e.ferr);
        end
        checks++;
        if (!ok || o.cyc != e.cyc) begin
            errors++;
            $display("FAIL min_div_latency: valid at cycle %0d, expected %0d", o.cyc, e.cyc);
        end
        clock_divider_i = 8'd4;
        drive_bit(1'b1, 10);
    endtask

    task automatic test_glitch();
        int busy_cnt;
        clock_divider_i = 8'd4;
        parity_bit_i    = 1'b0;
        two_stop_bits_i = 1'b0;
        busy_cnt        = 0;
        drive_bit(1'b0, 1);
        serial_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock_i);
            if (busy_o === 1'b1) busy_cnt++;
        end
        checks++;
        if (busy_cnt != 2) begin
            errors++;
            $display("FAIL glitch_busy: busy_o high for %0d cycles, expected 2", busy_cnt);
        end
        drive_bit(1'b1, 50);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_valid: %0d valid pulses, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_break();
        rec_t o;
        bit   ok;
        int   start;
        clock_divider_i = 8'd4;
        parity_bit_i    = 1'b0;
        two_stop_bits_i = 1'b0;
        start = cyc;
        drive_bit(1'b0, 80);
        get_obs(10, o, ok);
        checks++;
        if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL break_frame: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=00 perr=0 ferr=1 busy=1",
                     ok, o.data, o.perr, o.ferr, o.busy);
        end
        checks++;
        if (!ok || o.cyc != start + 1 + 41) begin
            errors++;
            $display("FAIL break_latency: valid at cycle %0d, expected %0d", o.cyc, start + 42);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL break_busy_held: busy_o=%b, expected 1", busy_o);
        end
        drive_bit(1'b1, 6);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL break_rearm: busy_o=%b, expected 0", busy_o);
        end
        drive_bit(1'b1, 60);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL break_second_valid: %0d extra valid pulses, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        rec_t o;
        rec_t e;
        bit   ok;
        clock_divider_i = 8'd4;
        parity_bit_i    = 1'b0;
        two_stop_bits_i = 1'b0;
        drive_bit(1'b0, 4);    // start bit
        drive_bit(1'b0, 12);   // data bits 0..2 of 0xF0
        drive_bit(1'b0, 2);    // into data bit 3
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_busy_before: busy_o=%b, expected 1", busy_o);
        end
        reset_i  = 1'b1;
        serial_i = 1'b1;
        @(posedge clock_i);
        #1;
        reset_i = 1'b0;
        checks++;
        if ({data_o, valid_o, parity_error_o, framing_error_o, busy_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_mid_values: got {data,valid,perr,ferr,busy}=%h expected 000",
                     {data_o, valid_o, parity_error_o, framing_error_o, busy_o});
        end
        drive_bit(1'b1, 80);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_valid: %0d valid pulses after abort, expected 0", obs_q.size());
        end
        obs_q.delete();
        send_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        get_obs(200, o, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {o.data, o.perr, o.ferr, o.busy} !== {e.data, e.perr, e.ferr, e.busy}) begin
            errors++;
            $display("FAIL reset_mid_next_frame: seen=%0b data=%h perr=%b ferr=%b busy=%b, expected data=%h perr=%b ferr=%b busy=%b",
                     ok, o.data, o.perr, o.ferr, o.busy, e.data, e.perr, e.ferr, e.busy);
        end
        checks++;
        if (!ok || o.cyc != e.cyc) begin
            errors++;
            $display("FAIL reset_mid_latency: valid at cycle %0d, expected %0d", o.cyc, e.cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_min_divider();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        drive_bit(1'b1, 10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_DIVIDER_WIDTH, default 8, width of clock_divider_i.
REQ-002 clock_i  input  1  sole clock; all logic on rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 serial_i  input  1  asynchronous serial line; idle high.
REQ-005 two_stop_bits_i  input  1  1 = expect two stop bits.
REQ-006 parity_bit_i  input  1  1 = frame carries a parity bit after data bit 7.
REQ-007 parity_even_i  input  1  1 = even parity, 0 = odd; ignored when parity_bit_i=0.
REQ-008 clock_divider_i  input  CLOCK_DIVIDER_WIDTH  clock_i cycles per bit (D).
REQ-009 data_o  output  8  last received byte, LSB first on the line.
REQ-010 valid_o  output  1  one-cycle pulse: data_o and error flags are valid.
REQ-011 parity_error_o  output  1  parity mismatch in the frame; meaningful while valid_o=1.
REQ-012 framing_error_o  output  1  any stop bit sampled low; meaningful while valid_o=1.
REQ-013 busy_o  output  1  high from start-bit detection until the frame ends or is rejected.

Function
REQ-014 serial_i SHALL pass through a 2-flop synchronizer before any use; all latencies include these 2 cycles.
REQ-015 Configuration inputs SHALL be latched at start-bit detection and held for the whole frame.
REQ-016 D values below 2 SHALL be treated as 2.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
REQ-018 IDLE -> START on a synchronized falling edge (previous 1, current 0); busy_o rises in the same cycle.
REQ-019 START samples the line floor(D/2) cycles after detection; if high -> IDLE, busy_o low, no valid_o (glitch rejection).
REQ-020 Each later bit SHALL be sampled exactly D cycles after the previous sample.
REQ-021 DATA captures 8 bits LSB first, then goes to PARITY if enabled, otherwise STOP1.
REQ-022 Parity error = (XOR of data bits ^ parity bit) != (parity_even_i ? 0 : 1).
REQ-023 STOP1 -> STOP2 if two stop bits; framing error if any stop sample is 0.
REQ-024 valid_o SHALL pulse 1 cycle, one cycle after the final stop sample; latency from the first clock edge sampling serial_i low = 2 + floor(D/2) + N*D + 1, N = 9 + parity + extra stop bit.
REQ-025 data_o and the error flags SHALL update with valid_o and hold until the next valid_o.
REQ-026 After a valid frame, the FSM SHALL return to IDLE with busy_o low in the same cycle valid_o is high.
REQ-027 After a framing error with the line low (break), the FSM SHALL enter WAIT_HIGH, busy_o high, and re-arm only after sampling the line high.
REQ-028 Back-to-back frames with 1 stop bit and no idle gap SHALL be received without loss.
REQ-029 Input changes to configuration during a frame SHALL not affect that frame.

Reset
REQ-030 Reset SHALL force IDLE and clear the bit counter and divider counter.
REQ-031 Output reset values: data_o=8'h00, valid_o=0, parity_error_o=0, framing_error_o=0, busy_o=0.
REQ-032 Synchronizer flops SHALL reset to 1 (idle line).
REQ-033 Reset mid-frame SHALL abort the frame with no valid_o.

Structure
REQ-034 No shared package; state encoding is local to uart_rx. The 8-bit data width is fixed, not parameterized.
REQ-035 The 2-flop synchronizer SHALL be one sub-module, uart_sync, reset to 1.

Verification
REQ-036 D=4, 8N1, line carries 0x55: exactly one valid_o, 41 cycles after the start edge; data_o=0x55; both errors 0.
REQ-037 Loopback from UartTx, D=4: write 0x55 then 0xAA back-to-back; two valid_o pulses, data 0x55 then 0xAA; no errors.
REQ-038 D=4, even parity, frame 0x07 with parity bit 0: valid_o with data_o=0x07 and parity_error_o=1; with parity bit 1, parity_error_o=0.
REQ-039 D=4, serial_i low for 1 cycle: busy_o pulses for 2 cycles, then low; no valid_o.
REQ-040 D=4, line held low for 20 bit times: one valid_o with data_o=0x00 and framing_error_o=1; busy_o stays high until the line returns high; no second valid_o.
REQ-041 Reset asserted during data bit 3: outputs return to reset values the next cycle; no valid_o; the next clean frame 0xA5 is received correctly.
